conv1_seq: RTL

//  Upstream sequencer for the binary conv1 (3x3 conv + 3x3 max-pool) datapath.

---
 rtl/conv1_seq_pkg.sv | 25 ++
 rtl/conv1_img_buf.sv | 63 ++++++
 rtl/conv1_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/conv1_seq_pkg.sv
// Shared definitions for the conv1 sequencer.
//   state_t   : sequencer FSM states (IDLE, LOAD, CLR, ACC, CAP, OUT)
//   KSIZE     : convolution kernel edge (3)
//   POOL      : max-pool window edge, also the pixel stride between windows (3)
//   NTAP      : kernel taps per window, also the number of pool lanes (9)
//   CMP_W     : width of the signed pooled result (6)
//   W_W       : width of one signed weight (8)
package conv1_seq_pkg;

    localparam int KSIZE = 3;
    localparam int POOL  = 3;
    localparam int NTAP  = 9;
    localparam int CMP_W = 6;
    localparam int W_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CLR  = 3'd2,
        ST_ACC  = 3'd3,
        ST_CAP  = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

endpackage

// File: rtl/conv1_img_buf.sv
// Binarized image buffer for the conv1 sequencer.
// Purpose: holds one IMG_H x IMG_W bit image written a row at a time and
// presents, for window (py,px) and kernel tap t, the 9 pool-lane pixels.
// Ports:
//   clk_i  : clock
//   we     : row write strobe
//   waddr  : row index to write
//   wdata  : row pixels, bit x = column x
//   py, px : pooling window coordinates
//   tap    : kernel tap index 0..8, (ky,kx) = (tap/3, tap%3)
//   lanes  : lanes[j] = img[3py+j/3+ky][3px+j%3+kx]
module conv1_img_buf
    import conv1_seq_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 3,
    parameter int PYW   = 2,
    parameter int PXW   = 2
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [IMG_W-1:0] wdata,
    input  logic [PYW-1:0]   py,
    input  logic [PXW-1:0]   px,
    input  logic [3:0]       tap,
    output logic [NTAP-1:0]  lanes
);

    localparam int CW = $clog2(IMG_W);

    // Contents need no reset: every frame rewrites all rows before use.
    logic [IMG_W-1:0] mem [IMG_H];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    logic [3:0] ky;
    logic [3:0] kx;

    always_comb begin
        ky = tap / 4'(KSIZE);
        kx = tap % 4'(KSIZE);
    end

    // One lane per pixel of the pool window; all lanes see the same tap.
    generate
        for (genvar gi = 0; gi < NTAP; gi++) begin : g_lane
            localparam int DY = gi / POOL;
            localparam int DX = gi % POOL;
            logic [AW-1:0] row;
            logic [CW-1:0] col;
            assign row       = AW'(POOL * int'(py) + DY + int'(ky));
            assign col       = CW'(POOL * int'(px) + DX + int'(kx));
            assign lanes[gi] = mem[row][col];
        end
    endgenerate

endmodule

// File: rtl/conv1_seq.sv
// Upstream sequencer for the binary conv1 (3x3 conv + 3x3 max-pool) datapath.
// Buffers one binarized image, holds the 9 conv weights, steps conv1 through
// CLR / 9 accumulate taps / capture for every pooling window, and streams the
// pooled 6-bit results out on a valid/ready port in raster order.
// Configuration macro: CONV1_SEQ_RELU_EN -- when defined, negative pooled
// results are clamped to zero at capture; otherwise they pass unmodified.
// Ports:
//   clk_i, rst            : clock, synchronous active-high reset
//   start, busy, done     : frame control / status (done = 1-cycle pulse)
//   row_valid/ready/data  : image row input, rows top to bottom
//   w_we, w_addr, w_data  : weight write port (IDLE only, addr 0..8)
//   conv_rst/we/and/sel   : conv1 control
//   conv_a, conv_w        : conv1 pixel lanes and packed weights
//   conv_cmp              : pooled result returned by conv1
//   out_valid/ready/data/last : result stream
module conv1_seq
    import conv1_seq_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                    clk_i,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    row_valid,
    output logic                    row_ready,
    input  logic [IMG_W-1:0]        row_data,
    input  logic                    w_we,
    input  logic [3:0]              w_addr,
    input  logic [W_W-1:0]          w_data,
    output logic                    conv_rst,
    output logic                    conv_we,
    output logic                    conv_and,
    output logic [3:0]              conv_sel,
    output logic [NTAP-1:0]         conv_a,
    output logic [NTAP*W_W-1:0]     conv_w,
    input  logic signed [CMP_W-1:0] conv_cmp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [CMP_W-1:0] out_data,
    output logic                    out_last
);

    localparam int PW  = (IMG_W - KSIZE + 1) / POOL;
    localparam int PH  = (IMG_H - KSIZE + 1) / POOL;
    localparam int AW  = $clog2(IMG_H);
    localparam int PYW = $clog2(PH + 1);
    localparam int PXW = $clog2(PW + 1);

    state_t                   state_reg;
    state_t                   state_next;
    logic [AW-1:0]            row_cnt_reg;
    logic [PYW-1:0]           py_reg;
    logic [PXW-1:0]           px_reg;
    logic [3:0]               tap_reg;
    logic signed [CMP_W-1:0]  out_data_reg;
    logic                     done_reg;
    logic [W_W-1:0]           w_regs [NTAP];
    logic [NTAP-1:0]          lanes;
    logic                     row_beat;
    logic                     row_last;
    logic                     win_last;

    assign row_beat = row_valid && (state_reg == ST_LOAD);
    assign row_last = (row_cnt_reg == AW'(IMG_H - 1));
    assign win_last = (py_reg == PYW'(PH - 1)) && (px_reg == PXW'(PW - 1));

    conv1_img_buf #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW),
        .PYW   (PYW),
        .PXW   (PXW)
    ) u_img_buf (
        .clk_i (clk_i),
        .we    (row_beat),
        .waddr (row_cnt_reg),
        .wdata (row_data),
        .py    (py_reg),
        .px    (px_reg),
        .tap   (tap_reg),
        .lanes (lanes)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)                 state_next = ST_LOAD;
            ST_LOAD: if (row_beat && row_last)  state_next = ST_CLR;
            ST_CLR:                             state_next = ST_ACC;
            ST_ACC:  if (tap_reg == 4'(NTAP - 1)) state_next = ST_CAP;
            ST_CAP:                             state_next = ST_OUT;
            ST_OUT:  if (out_ready)             state_next = win_last ? ST_IDLE : ST_CLR;
            default:                            state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // conv1's accumulators are also cleared while rst is held.
    always_comb begin
        busy      = 1'b1;
        row_ready = 1'b0;
        conv_rst  = rst;
        conv_we   = 1'b1;
        conv_and  = 1'b0;
        conv_sel  = '0;
        conv_a    = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_reg)
            ST_IDLE: busy = 1'b0;
            ST_LOAD: row_ready = 1'b1;
            ST_CLR:  conv_rst = 1'b1;
            ST_ACC: begin
                conv_we  = 1'b0;
                conv_sel = tap_reg;
                conv_a   = lanes;
            end
            ST_CAP:  conv_and = 1'b1;
            ST_OUT: begin
                out_valid = 1'b1;
                out_last  = win_last;
            end
            default: ;
        endcase
    end

    // ---------------- counters and result capture ----------------
    always_ff @(posedge clk_i) begin
        if (rst) begin
            row_cnt_reg  <= '0;
            py_reg       <= '0;
            px_reg       <= '0;
            tap_reg      <= '0;
            out_data_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    row_cnt_reg <= '0;
                    py_reg      <= '0;
                    px_reg      <= '0;
                    tap_reg     <= '0;
                end
                ST_LOAD: if (row_beat) row_cnt_reg <= row_cnt_reg + 1'b1;
                ST_ACC:  tap_reg <= (tap_reg == 4'(NTAP - 1)) ? 4'd0 : tap_reg + 4'd1;
                ST_CAP: begin
`ifdef CONV1_SEQ_RELU_EN
                    out_data_reg <= conv_cmp[CMP_W-1] ? '0 : conv_cmp;
`else
                    out_data_reg <= conv_cmp;
`endif
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (win_last) begin
                            done_reg <= 1'b1;
                            py_reg   <= '0;
                            px_reg   <= '0;
                        end else if (px_reg == PXW'(PW - 1)) begin
                            px_reg <= '0;
                            py_reg <= py_reg + 1'b1;
                        end else begin
                            px_reg <= px_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_data_reg;
    assign done     = done_reg;

    // ---------------- weights ----------------
    always_ff @(posedge clk_i) begin
        if (rst) begin
            for (int k = 0; k < NTAP; k++) begin
                w_regs[k] <= '0;
            end
        end else if (w_we && (state_reg == ST_IDLE) && (w_addr < 4'(NTAP))) begin
            w_regs[w_addr] <= w_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NTAP; gi++) begin : g_wpack
            assign conv_w[gi*W_W +: W_W] = w_regs[gi];
        end
    endgenerate

endmodule
